// File: rtl/ddr2_port_arbiter.sv
// Arbitrates the single DDR2 port between the core data path and a FIFO-staged
// UART DMA stream that fills a ring segment; grants are frozen while DDR2 stalls.
module ddr2_port_arbiter #(
    parameter logic [31:0] SEG_BASE   = 32'h0010_0000,
    parameter int          SEG_WORDS  = 512,
    parameter int          FIFO_DEPTH = 8,
    parameter int          HI_WATER   = 6
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            dma_ready,
    input  logic [31:0]                     dma_data,
    input  logic                            core_en,
    input  logic                            core_we,
    input  logic [31:0]                     core_addr,
    input  logic [31:0]                     core_wd,
    output logic [31:0]                     core_rd,
    output logic                            core_stall,
    output logic                            ddr_en,
    output logic                            ddr_we,
    output logic [31:0]                     ddr_addr,
    output logic [31:0]                     ddr_wd,
    input  logic [31:0]                     ddr_rd,
    input  logic                            ddr_stall,
    output logic [$clog2(SEG_WORDS)-1:0]    ring_ptr,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow
);

    localparam int PTR_W = $clog2(SEG_WORDS);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, LOCK_CORE, LOCK_DMA} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DMA} owner_t;

    state_t             state_q, state_d;
    owner_t             owner;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [PTR_W-1:0]   ring_ptr_q, ring_ptr_d;
    logic               overflow_q, overflow_d;
    logic [31:0]        fifo_mem_q [FIFO_DEPTH];
    logic               fifo_full;
    logic               pop;
    logic               push_ok;

    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign ring_ptr   = ring_ptr_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

    // Ownership is combinational in IDLE so a grant costs no extra cycle.
    always_comb begin
        owner = OWN_NONE;
        case (state_q)
            LOCK_CORE: owner = OWN_CORE;
            LOCK_DMA:  owner = OWN_DMA;
            default: begin
                if (level_q >= LVL_W'(HI_WATER))
                    owner = OWN_DMA;
                else if (core_en)
                    owner = OWN_CORE;
                else if (level_q != '0)
                    owner = OWN_DMA;
            end
        endcase
    end

    always_comb begin
        ddr_en     = 1'b0;
        ddr_we     = 1'b0;
        ddr_addr   = '0;
        ddr_wd     = '0;
        core_rd    = '0;
        core_stall = 1'b0;
        case (owner)
            OWN_CORE: begin
                ddr_en     = core_en;
                ddr_we     = core_we;
                ddr_addr   = core_addr;
                ddr_wd     = core_wd;
                core_rd    = ddr_rd;
                core_stall = ddr_stall;
            end
            OWN_DMA: begin
                ddr_en     = 1'b1;
                ddr_we     = 1'b1;
                ddr_addr   = SEG_BASE + 32'(ring_ptr_q);
                ddr_wd     = fifo_mem_q[rd_idx_q];
                core_stall = core_en;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pop        = (owner == OWN_DMA) && !ddr_stall;
        push_ok    = dma_ready && (!fifo_full || pop);
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        level_d    = level_q;
        ring_ptr_d = ring_ptr_q;
        overflow_d = overflow_q | (dma_ready & fifo_full & !pop);

        case (state_q)
            IDLE: begin
                if (ddr_stall && owner == OWN_CORE && core_en)
                    state_d = LOCK_CORE;
                else if (ddr_stall && owner == OWN_DMA)
                    state_d = LOCK_DMA;
            end
            default: begin
                if (!ddr_stall)
                    state_d = IDLE;
            end
        endcase

        if (push_ok)
            wr_idx_d = wr_idx_q + IDX_W'(1);
        if (pop) begin
            rd_idx_d   = rd_idx_q + IDX_W'(1);
            ring_ptr_d = ring_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop)
            level_d = level_q + LVL_W'(1);
        else if (!push_ok && pop)
            level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            level_q    <= '0;
            ring_ptr_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            level_q    <= level_d;
            ring_ptr_q <= ring_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the level counter alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push_ok)
            fifo_mem_q[wr_idx_q] <= dma_data;
    end

endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// Directed bench for ddr2_port_arbiter: expected DDR2 transactions are queued as
// stimulus is issued and a monitor checks every completed transaction in order.
module tb_ddr2_port_arbiter;

    localparam logic [31:0] SEG_BASE = 32'h0010_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        dma_ready;
    logic [31:0] dma_data;
    logic        core_en;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wd;
    logic [31:0] core_rd;
    logic        core_stall;
    logic        ddr_en;
    logic        ddr_we;
    logic [31:0] ddr_addr;
    logic [31:0] ddr_wd;
    logic [31:0] ddr_rd;
    logic        ddr_stall;
    logic [8:0]  ring_ptr;
    logic [3:0]  fifo_level;
    logic        overflow;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } txn_t;

    txn_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   ptrModel = 0;

    ddr2_port_arbiter #(
        .SEG_BASE(SEG_BASE), .SEG_WORDS(512), .FIFO_DEPTH(8), .HI_WATER(6)
    ) dut (
        .clock(clock), .reset(reset),
        .dma_ready(dma_ready), .dma_data(dma_data),
        .core_en(core_en), .core_we(core_we), .core_addr(core_addr),
        .core_wd(core_wd), .core_rd(core_rd), .core_stall(core_stall),
        .ddr_en(ddr_en), .ddr_we(ddr_we), .ddr_addr(ddr_addr),
        .ddr_wd(ddr_wd), .ddr_rd(ddr_rd), .ddr_stall(ddr_stall),
        .ring_ptr(ring_ptr), .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic cEn, input logic cWe,
                                 input logic [31:0] cAddr, input logic [31:0] cWd,
                                 input logic dRdy, input logic [31:0] dData,
                                 input logic stall);
        core_en   = cEn;
        core_we   = cWe;
        core_addr = cAddr;
        core_wd   = cWd;
        dma_ready = dRdy;
        dma_data  = dData;
        ddr_stall = stall;
        #1;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic expectCore();
        txn_t t;
        t.we   = core_we;
        t.addr = core_addr;
        t.wd   = core_wd;
        expQ.push_back(t);
    endtask

    task automatic expectDma(input logic [31:0] data);
        txn_t t;
        t.we   = 1'b1;
        t.addr = SEG_BASE + 32'(ptrModel);
        t.wd   = data;
        expQ.push_back(t);
        ptrModel = (ptrModel + 1) % 512;
    endtask

    // Every completed DDR2 transaction must match the oldest expected one.
    always @(negedge clock) begin
        if (!reset && ddr_en && !ddr_stall) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_txn: got addr %h wd %h, expected none",
                         ddr_addr, ddr_wd);
            end else begin
                txn_t e;
                e = expQ.pop_front();
                checkOutput("txn_we", 32'(ddr_we), 32'(e.we));
                checkOutput("txn_addr", ddr_addr, e.addr);
                checkOutput("txn_wd", ddr_wd, e.wd);
            end
        end
    end

    initial begin
        reset  = 1'b1;
        ddr_rd = 32'h0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        checkOutput("reset_ddr_en", 32'(ddr_en), 0);
        checkOutput("reset_core_stall", 32'(core_stall), 0);
        checkOutput("reset_core_rd", core_rd, 0);
        checkOutput("reset_level", 32'(fifo_level), 0);
        checkOutput("reset_ring_ptr", 32'(ring_ptr), 0);
        checkOutput("reset_overflow", 32'(overflow), 0);
        reset = 1'b0;
        cycle();

        // Core-only write and read.
        applyStimulus(1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0);
        expectCore();
        checkOutput("core_wr_en", 32'(ddr_en), 1);
        checkOutput("core_wr_addr", ddr_addr, 32'h40);
        checkOutput("core_wr_stall", 32'(core_stall), 0);
        cycle();
        ddr_rd = 32'hCAFE0001;
        applyStimulus(1, 0, 32'h44, 32'h0, 0, 0, 0);
        expectCore();
        checkOutput("core_rd_data", core_rd, 32'hCAFE0001);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // DMA only: three words land at SEG_BASE+0..2.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 32'hA + 32'(i), 0);
            expectDma(32'hA + 32'(i));
            cycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        checkOutput("dma_ring_ptr", 32'(ring_ptr), 3);
        checkOutput("dma_level", 32'(fifo_level), 0);

        // Contention: core wins below the high-water mark, DMA at it.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, 32'h80, 32'h1111, 1, 32'h100 + 32'(i), 0);
            expectCore();
            if (i == 2) begin
                checkOutput("cont_lvl2_stall", 32'(core_stall), 0);
                checkOutput("cont_lvl2_addr", ddr_addr, 32'h80);
            end
            cycle();
        end
        applyStimulus(1, 1, 32'h80, 32'h1111, 0, 0, 0);
        checkOutput("cont_hi_level", 32'(fifo_level), 6);
        checkOutput("cont_hi_stall", 32'(core_stall), 1);
        checkOutput("cont_hi_addr", ddr_addr, SEG_BASE + 32'd3);
        expectDma(32'h100);
        cycle();
        expectCore();
        checkOutput("cont_back_core", 32'(core_stall), 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 6; i++) expectDma(32'h100 + 32'(i));
        repeat (6) cycle();
        checkOutput("cont_drained", 32'(fifo_level), 0);

        // Lock: a stalled DMA write keeps the port while core_en rises.
        applyStimulus(0, 0, 0, 0, 1, 32'h55, 1);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("lock_addr_c1", ddr_addr, SEG_BASE + 32'd9);
        for (int i = 2; i <= 4; i++) begin
            cycle();
            applyStimulus(1, 1, 32'h90, 32'h2222, 0, 0, 1);
            checkOutput("lock_addr_held", ddr_addr, SEG_BASE + 32'd9);
            checkOutput("lock_core_stall", 32'(core_stall), 1);
        end
        cycle();
        applyStimulus(1, 1, 32'h90, 32'h2222, 0, 0, 0);
        expectDma(32'h55);
        checkOutput("lock_done_addr", ddr_addr, SEG_BASE + 32'd9);
        cycle();
        expectCore();
        checkOutput("lock_core_grant", 32'(core_stall), 0);
        checkOutput("lock_core_addr", ddr_addr, 32'h90);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Ring wrap: walk the pointer to 511 and complete one more write.
        for (int i = 0; i < 501; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 32'(i), 0);
            expectDma(32'(i));
            cycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        checkOutput("wrap_ptr_511", 32'(ring_ptr), 511);
        applyStimulus(0, 0, 0, 0, 1, 32'hF00D, 0);
        expectDma(32'hF00D);
        cycle();
        applyStimulus(0, 0, 0, 0, 1, 32'hBEE, 0);
        expectDma(32'hBEE);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        cycle();
        checkOutput("wrap_ptr_1", 32'(ring_ptr), 1);

        // Overflow: DDR2 stalled, nine pushes into an eight-deep FIFO.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 32'h300 + 32'(i), 1);
            cycle();
        end
        applyStimulus(0, 0, 0, 0, 1, 32'h308, 1);
        checkOutput("ovf_level8", 32'(fifo_level), 8);
        checkOutput("ovf_before", 32'(overflow), 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("ovf_level_full", 32'(fifo_level), 8);
        checkOutput("ovf_sticky", 32'(overflow), 1);
        checkOutput("ovf_ddr_en", 32'(ddr_en), 1);

        // Reset mid-transaction acts immediately, without a clock edge.
        reset = 1'b1;
        #1;
        checkOutput("midrst_ddr_en", 32'(ddr_en), 0);
        checkOutput("midrst_level", 32'(fifo_level), 0);
        checkOutput("midrst_ring_ptr", 32'(ring_ptr), 0);
        checkOutput("midrst_overflow", 32'(overflow), 0);
        ptrModel = 0;
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        cycle();
        cycle();
        checkOutput("queue_empty", 32'(expQ.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
